// File: rtl/usng_pkg.sv
// -----------------------------------------------------------------------------
// usng_pkg -- shared definitions for the unipolar stochastic number generator.
//
// Contents:
//    state_e    : two-state controller encoding (IDLE / RUN)
//    lfsr_taps  : maximal-length Fibonacci LFSR tap mask for widths 4..16.
//                 Bit i of the mask selects register bit i. The MSB is always
//                 a tap, which the zero-insertion logic relies on.
// -----------------------------------------------------------------------------
package usng_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Primitive polynomials for XOR feedback into bit 0 of a left-shifting
   // register. The return value is always 16 bits wide; callers keep the low
   // <width> bits.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      case (width)
         4:       lfsr_taps = 16'h000C;   // x^4 + x^3 + 1
         5:       lfsr_taps = 16'h0014;   // x^5 + x^3 + 1
         6:       lfsr_taps = 16'h0030;   // x^6 + x^5 + 1
         7:       lfsr_taps = 16'h0060;   // x^7 + x^6 + 1
         8:       lfsr_taps = 16'h00B8;   // x^8 + x^6 + x^5 + x^4 + 1
         9:       lfsr_taps = 16'h0110;   // x^9 + x^5 + 1
         10:      lfsr_taps = 16'h0240;   // x^10 + x^7 + 1
         11:      lfsr_taps = 16'h0500;   // x^11 + x^9 + 1
         12:      lfsr_taps = 16'h0829;   // x^12 + x^6 + x^4 + x + 1
         13:      lfsr_taps = 16'h100D;   // x^13 + x^4 + x^3 + x + 1
         14:      lfsr_taps = 16'h2015;   // x^14 + x^5 + x^3 + x + 1
         15:      lfsr_taps = 16'h6000;   // x^15 + x^14 + 1
         16:      lfsr_taps = 16'hD008;   // x^16 + x^15 + x^13 + x^4 + 1
         default: lfsr_taps = 16'h00B8;
      endcase
   endfunction

endpackage

// File: rtl/usng_lfsr.sv
// -----------------------------------------------------------------------------
// usng_lfsr -- WIDTH-bit Fibonacci LFSR with zero-state insertion. Each
// period visits every value 0 .. 2^WIDTH-1 exactly once.
//
// Ports:
//    iClk      : clock, rising edge
//    iRst      : synchronous active-high reset, register returns to SEED
//    iLoad     : restart the sequence at SEED (wins over iAdvance)
//    iAdvance  : step the register by one state
//    oRnd      : random value for the bit being produced this cycle:
//                SEED while loading, otherwise the successor of the register
// -----------------------------------------------------------------------------
module usng_lfsr
   import usng_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iLoad,
   input  logic             iAdvance,
   output logic [WIDTH-1:0] oRnd
);

   localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] next_state;
   logic             fb;

   always_comb begin
      fb = ^(state_q & TAPS);
      // With every bit below the MSB clear the register is either 100..0 or
      // 000..0. Inverting the feedback there splices the all-zero state into
      // the maximal-length cycle: 100..0 -> 000..0 -> 000..1.
      if (state_q[WIDTH-2:0] == '0) begin
         fb = ~fb;
      end
      next_state = {state_q[WIDTH-2:0], fb};

      state_d = state_q;
      if (iLoad) begin
         state_d = SEED;
      end else if (iAdvance) begin
         state_d = next_state;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign oRnd = iLoad ? SEED : next_state;

endmodule

// File: rtl/usng_uni.sv
// -----------------------------------------------------------------------------
// usng_uni -- generates a pair of unipolar stochastic bit streams of length
// 2^BITWIDTH from two unsigned values.
//
// Parameters:
//    BITWIDTH : value width, 4..16; one stream lasts 2^BITWIDTH cycles
//    SEED     : nonzero LFSR start state
//
// Ports:
//    iClk   : clock, rising edge
//    iRst   : synchronous active-high reset
//    iStart : start one stream (only looked at while idle)
//    iValA  : value for stream A, probability iValA / 2^BITWIDTH
//    iValB  : value for stream B
//    iAbort : end the running stream at once
//    oBusy  : high while a stream is running
//    oValid : oA/oB hold a stream bit this cycle
//    oA/oB  : stream bits
//    oDone  : one-cycle pulse with the final stream bit
//
// Build option:
//    USNG_DECORR_EN : if defined, stream B is compared against the
//                     bit-reversed random value, which decorrelates it from
//                     stream A. Otherwise both streams share the same random
//                     value and are maximally correlated.
// -----------------------------------------------------------------------------
module usng_uni
   import usng_pkg::*;
#(
   parameter int unsigned         BITWIDTH = 8,
   parameter logic [BITWIDTH-1:0] SEED     = BITWIDTH'('hA5)
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iStart,
   input  logic [BITWIDTH-1:0] iValA,
   input  logic [BITWIDTH-1:0] iValB,
   input  logic                iAbort,
   output logic                oBusy,
   output logic                oValid,
   output logic                oA,
   output logic                oB,
   output logic                oDone
);

   localparam logic [BITWIDTH-1:0] CNT_LAST = '1;

   state_e              state_q, state_d;
   logic [BITWIDTH-1:0] val_a_q, val_a_d;
   logic [BITWIDTH-1:0] val_b_q, val_b_d;
   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                a_q, a_d;
   logic                b_q, b_d;
   logic                done_q, done_d;

   logic                accept;
   logic                lfsr_adv;
   logic [BITWIDTH-1:0] rnd;
   logic [BITWIDTH-1:0] rnd_b;
   logic [BITWIDTH-1:0] cmp_a;
   logic [BITWIDTH-1:0] cmp_b;
   logic [BITWIDTH-1:0] cnt_inc;
   logic                bit_a;
   logic                bit_b;

   assign accept = (state_q == ST_IDLE) && iStart;

   usng_lfsr #(
      .WIDTH (BITWIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .iClk     (iClk),
      .iRst     (iRst),
      .iLoad    (accept),
      .iAdvance (lfsr_adv),
      .oRnd     (rnd)
   );

`ifdef USNG_DECORR_EN
   for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_rev
      assign rnd_b[gi] = rnd[BITWIDTH-1-gi];
   end
`else
   assign rnd_b = rnd;
`endif

   // Bit 0 is produced in the accept cycle itself so it can leave the output
   // register one cycle later; it therefore compares the live inputs rather
   // than the values being latched.
   assign cmp_a   = accept ? iValA : val_a_q;
   assign cmp_b   = accept ? iValB : val_b_q;
   assign bit_a   = rnd < cmp_a;
   assign bit_b   = rnd_b < cmp_b;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      val_a_d  = val_a_q;
      val_b_d  = val_b_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      a_d      = 1'b0;
      b_d      = 1'b0;
      done_d   = 1'b0;
      lfsr_adv = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               state_d = ST_RUN;
               val_a_d = iValA;
               val_b_d = iValB;
               cnt_d   = '0;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               a_d     = bit_a;
               b_d     = bit_b;
            end
         end
         ST_RUN: begin
            // cnt_q is the index of the bit currently on the outputs.
            if (iAbort || (cnt_q == CNT_LAST)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d    = cnt_inc;
               lfsr_adv = 1'b1;
               busy_d   = 1'b1;
               valid_d  = 1'b1;
               a_d      = bit_a;
               b_d      = bit_b;
               done_d   = (cnt_inc == CNT_LAST);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         val_a_q <= '0;
         val_b_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         val_a_q <= val_a_d;
         val_b_q <= val_b_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         done_q  <= done_d;
      end
   end

   assign oBusy  = busy_q;
   assign oValid = valid_q;
   assign oA     = a_q;
   assign oB     = b_q;
   assign oDone  = done_q;

endmodule

// File: tb/tb_usng_uni.sv
// -----------------------------------------------------------------------------
// tb_usng_uni -- scoreboard bench for usng_uni at BITWIDTH = 8.
// Expected ones counts are pushed when a stream is started and popped when
// the DUT signals oDone. Expected B and A&B counts follow USNG_DECORR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usng_uni;

   localparam int W = 8;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [W-1:0] val_a;
   logic [W-1:0] val_b;
   logic         busy;
   logic         valid;
   logic         oa;
   logic         ob;
   logic         done;

   always #5 clk = ~clk;

   usng_uni #(
      .BITWIDTH (W)
   ) dut (
      .iClk   (clk),
      .iRst   (rst),
      .iStart (start),
      .iValA  (val_a),
      .iValB  (val_b),
      .iAbort (abort),
      .oBusy  (busy),
      .oValid (valid),
      .oA     (oa),
      .oB     (ob),
      .oDone  (done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int a;
      int b;
      int ab;
   } exp_t;

   exp_t sb[$];

   // Reference model of the comparator stage: a full stream presents every
   // random value once, so the counts follow from the thresholds alone.
   function automatic int exp_ones(input int a, input int b, input bit want_a, input bit want_b);
      int           n;
      logic [W-1:0] r;
      logic [W-1:0] rb;
      bit           ha;
      bit           hb;
      n = 0;
      for (int i = 0; i < N; i++) begin
         r = W'(i);
`ifdef USNG_DECORR_EN
         for (int j = 0; j < W; j++) rb[j] = r[W-1-j];
`else
         rb = r;
`endif
         ha = int'(r) < a;
         hb = int'(rb) < b;
         if ((!want_a || ha) && (!want_b || hb)) n++;
      end
      return n;
   endfunction

   // Output monitor
   int           bits_seen = 0;
   int           ones_a    = 0;
   int           ones_b    = 0;
   int           ones_ab   = 0;
   int           done_cnt  = 0;
   logic [N-1:0] cur_a, cur_b, last_a, last_b;

   always @(negedge clk) begin : mon
      exp_t e;
      check_eq("busy_eq_valid", int'(busy), int'(valid));
      if (!valid) begin
         check_eq("quiet_outputs", int'({oa, ob, done}), 0);
         bits_seen = 0;
         ones_a    = 0;
         ones_b    = 0;
         ones_ab   = 0;
      end else begin
         if (bits_seen < N) begin
            cur_a[bits_seen] = oa;
            cur_b[bits_seen] = ob;
         end
         bits_seen++;
         if (bits_seen == N + 1) check_eq("stream_overrun", bits_seen, N);
         ones_a  += int'(oa);
         ones_b  += int'(ob);
         ones_ab += int'(oa & ob);
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check_eq("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check_eq("stream_len", bits_seen, N);
               check_eq("ones_a", ones_a, e.a);
               check_eq("ones_b", ones_b, e.b);
               check_eq("ones_ab", ones_ab, e.ab);
            end
            $display("stream %0d: len=%0d onesA=%0d onesB=%0d onesAB=%0d",
                     done_cnt, bits_seen, ones_a, ones_b, ones_ab);
            last_a = cur_a;
            last_b = cur_b;
         end
      end
   end

   // Drive a start request; optionally expect the stream to complete.
   task automatic start_stream(input int a, input int b, input bit push, input bit with_abort);
      exp_t e;
      @(negedge clk); #1;
      val_a = W'(a);
      val_b = W'(b);
      start = 1'b1;
      abort = with_abort;
      if (push) begin
         e.a  = exp_ones(a, b, 1'b1, 1'b0);
         e.b  = exp_ones(a, b, 1'b0, 1'b1);
         e.ab = exp_ones(a, b, 1'b1, 1'b1);
         sb.push_back(e);
      end
      @(negedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check_eq("first_valid", int'(valid), 1);
      check_eq("first_bit_idx", bits_seen, 1);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < N + 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (done) seen = 1'b1;
      end
      if (!seen) check_eq("done_timeout", 0, 1);
   endtask

   task automatic wait_bits(input int k);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < N + 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (bits_seen == k) seen = 1'b1;
      end
      if (!seen) check_eq("bits_timeout", 0, 1);
   endtask

   logic [N-1:0] ref_a, ref_b;
   int           d0;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      val_a = '0;
      val_b = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_outputs", int'({busy, valid, oa, ob, done}), 0);
      rst = 1'b0;

      // Abort while idle does nothing.
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      check_eq("idle_abort_busy", int'(busy), 0);

      // Extremes: no ones on A, all but one on B.
      start_stream(0, 255, 1'b1, 1'b0);
      wait_done();

      // Mid values; a start held through the oDone cycle must be dropped.
      start_stream(128, 64, 1'b1, 1'b0);
      wait_done();
      ref_a = last_a;
      ref_b = last_b;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      check_eq("start_at_done_ignored", int'(busy), 0);

      // Equal values, start together with abort in idle: start wins.
      start_stream(128, 128, 1'b1, 1'b1);
      wait_done();

      // Start pulse and input change mid-stream have no effect.
      start_stream(200, 30, 1'b1, 1'b0);
      wait_bits(10);
      start = 1'b1;
      val_a = W'(7);
      val_b = W'(99);
      @(negedge clk); #1;
      start = 1'b0;
      wait_done();

      // Abort mid-stream, then a full restart.
      start_stream(100, 150, 1'b0, 1'b0);
      wait_bits(100);
      d0    = done_cnt;
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      check_eq("abort_valid", int'(valid), 0);
      check_eq("abort_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("abort_no_done", done_cnt, d0);
      start_stream(100, 150, 1'b1, 1'b0);
      wait_done();

      // Reset mid-stream overrides start/abort; restart replays the stream.
      start_stream(128, 64, 1'b0, 1'b0);
      wait_bits(50);
      d0    = done_cnt;
      rst   = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk); #1;
      check_eq("midrst_outputs", int'({busy, valid, oa, ob, done}), 0);
      rst   = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      check_eq("midrst_no_done", done_cnt, d0);
      start_stream(128, 64, 1'b1, 1'b0);
      wait_done();
      check_eq("replay_a", int'(last_a == ref_a), 1);
      check_eq("replay_b", int'(last_b == ref_b), 1);

      @(negedge clk); #1;
      check_eq("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
